led_frame_scheduler: RTL

Sequences the WS2812B LED driver and manages double buffering between the frame renderer and the driver. A refresh timer issues periodic ctrl_update pulses with the front-buffer id. The front and back buffers are swapped only between transfers, once the renderer reports a completed frame. Sits between the renderer control logic and led_driver's ctrl_* interface.

---
 rtl/led_frame_scheduler_pkg.sv | 17 +
 rtl/led_frame_scheduler_if.sv | 32 +++
 rtl/led_sched_refresh_timer.sv | 29 ++
 rtl/led_frame_scheduler.sv | 120 ++++++++++++
 4 files changed

// File: rtl/led_frame_scheduler_pkg.sv
// Shared types and defaults for the LED frame scheduler.
// FSM state encoding and default buffer ids.
package led_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_SWAP
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BUF0_ID    = 0;
  localparam int DEF_BUF1_ID    = 1;

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Renderer and led_driver control signals of the frame scheduler.
// master = scheduler side, slave = renderer/driver side.
interface led_frame_scheduler_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  render_done;
  logic                  render_start;
  logic [DATA_WIDTH-1:0] render_buf_id;
  logic                  ctrl_update;
  logic [DATA_WIDTH-1:0] ctrl_buf_id;
  logic                  ctrl_update_done;

  modport master (
    input  render_done,
    input  ctrl_update_done,
    output render_start,
    output render_buf_id,
    output ctrl_update,
    output ctrl_buf_id
  );

  modport slave (
    output render_done,
    output ctrl_update_done,
    input  render_start,
    input  render_buf_id,
    input  ctrl_update,
    input  ctrl_buf_id
  );

endinterface

// File: rtl/led_sched_refresh_timer.sv
// Refresh timer: counts 0..PERIOD-1 while enabled, ticks on the last count.
// Held at zero while disabled.
module led_sched_refresh_timer #(
  parameter int PERIOD = 1666667,
  parameter int WIDTH  = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffer scheduler between renderer and WS2812B led_driver.
// Optional watchdog on ST_WAIT_DONE: define LED_SCHED_WATCHDOG_EN.
module led_frame_scheduler
  import led_frame_scheduler_pkg::*;
#(
  parameter int                    DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int                    REFRESH_PERIOD = 1666667,
  parameter int                    TIMER_WIDTH    = 24,
  parameter logic [DATA_WIDTH-1:0] BUF0_ID        = DATA_WIDTH'(DEF_BUF0_ID),
  parameter logic [DATA_WIDTH-1:0] BUF1_ID        = DATA_WIDTH'(DEF_BUF1_ID),
  parameter int unsigned           WDT_CYCLES     = 4000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  led_frame_scheduler_if.master  bus,
  output logic                   busy,
  output logic                   overrun,
  output logic [15:0]            frame_count,
  output logic                   wdt_timeout
);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] front;
  logic [DATA_WIDTH-1:0] back;
  logic                  pending;
  logic                  pend_eff;
  logic                  armed;
  logic                  tick;
  logic                  wdt_hit;

  led_sched_refresh_timer #(
    .PERIOD (REFRESH_PERIOD),
    .WIDTH  (TIMER_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign pend_eff = pending | bus.render_done;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:      if (armed) state_nxt = ST_IDLE;
      ST_IDLE:      if (tick) state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.ctrl_update_done) begin
          state_nxt = pend_eff ? ST_SWAP : ST_IDLE;
        end else if (wdt_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SWAP:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_INIT;
    endcase
  end

  // armed keeps render_start low while reset is still asserted
  assign bus.render_start  = (state == ST_INIT && armed) ||
                             (state == ST_SWAP);
  assign bus.ctrl_update   = (state == ST_START);
  assign bus.ctrl_buf_id   = front;
  assign bus.render_buf_id = back;
  assign busy              = (state == ST_START) ||
                             (state == ST_WAIT_DONE);
  assign overrun           = tick && (state != ST_IDLE);
  assign wdt_timeout       = wdt_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_INIT;
      armed       <= 1'b0;
      front       <= BUF0_ID;
      back        <= BUF1_ID;
      pending     <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (state == ST_SWAP) begin
        front   <= back;
        back    <= front;
        pending <= 1'b0;
      end else if (bus.render_done) begin
        pending <= 1'b1;
      end
      if (state == ST_WAIT_DONE && bus.ctrl_update_done) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

`ifdef LED_SCHED_WATCHDOG_EN
  logic [31:0] wdt_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if (state != ST_WAIT_DONE) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 32'd1;
    end
  end

  assign wdt_hit = (state == ST_WAIT_DONE) &&
                   !bus.ctrl_update_done &&
                   (wdt_cnt == WDT_CYCLES);
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_CYCLES;
  assign wdt_hit    = 1'b0;
`endif

endmodule
